// File: rtl/vtx1_eval_arbiter.sv
// Round-robin arbiter sharing one combinational vtx1 evaluator among NUM_REQ requesters.
// Registers the granted vector onto the function inputs and returns the captured result.
module vtx1_eval_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned VEC_W   = 27,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [VEC_W-1:0]         fn_x,
  input  logic                     fn_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IdW-1:0]           rsp_id,
  output logic                     rsp_y,
  input  logic                     clr_counts,
  output logic [CNT_W-1:0]         eval_count,
  output logic [CNT_W-1:0]         hit_count
);

  typedef enum logic [1:0] {StIdle, StEval, StHold} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   fn_x_q, fn_x_d;
  logic [IdW-1:0]     gid_q, gid_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_y_q, rsp_y_d;
  logic [CNT_W-1:0]   eval_count_q, eval_count_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;

  logic               accept_ok;
  logic               accept;
  logic               grant_found;
  logic [IdW-1:0]     grant;
  logic [IdW-1:0]     cand;
  int unsigned        cand_int;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand_int    = 0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_int = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand     = IdW'(cand_int);
      if (!grant_found && req_valid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign accept_ok = (state_q == StIdle) || ((state_q == StHold) && rsp_ready);
  assign accept    = accept_ok && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;

  always_comb begin
    state_d      = state_q;
    fn_x_d       = fn_x_q;
    gid_d        = gid_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    eval_count_d = eval_count_q;
    hit_count_d  = hit_count_q;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StEval;
      end
      StEval: begin
        rsp_valid_d = 1'b1;
        rsp_y_d     = fn_y;
        rsp_id_d    = gid_q;
        state_d     = StHold;
        if (eval_count_q != '1) eval_count_d = eval_count_q + 1'b1;
        if (fn_y && (hit_count_q != '1)) hit_count_d = hit_count_q + 1'b1;
      end
      StHold: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? StEval : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // fn_x only moves on an accept so the shared function never sees a stray vector.
    if (accept) begin
      fn_x_d   = req_vec[grant*VEC_W +: VEC_W];
      gid_d    = grant;
      rr_ptr_d = grant;
    end

    if (clr_counts) begin
      eval_count_d = '0;
      hit_count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      fn_x_q       <= '0;
      gid_q        <= '0;
      rr_ptr_q     <= IdW'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_y_q      <= 1'b0;
      eval_count_q <= '0;
      hit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      fn_x_q       <= fn_x_d;
      gid_q        <= gid_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      eval_count_q <= eval_count_d;
      hit_count_q  <= hit_count_d;
    end
  end

  assign fn_x       = fn_x_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_y      = rsp_y_q;
  assign eval_count = eval_count_q;
  assign hit_count  = hit_count_q;

endmodule

// File: tb/tb_vtx1_eval_arbiter.sv
// Bench for vtx1_eval_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vtx1_eval_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned VW  = 27;
  localparam int unsigned CW  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR*VW-1:0]  req_vec;
  logic [NR-1:0]     req_ready;
  logic [VW-1:0]     fn_x;
  logic              fn_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic              rsp_y;
  logic              clr_counts;
  logic [CW-1:0]     eval_count;
  logic [CW-1:0]     hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  vtx1_eval_arbiter #(
    .NUM_REQ(NR),
    .VEC_W  (VW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_vec   (req_vec),
    .req_ready (req_ready),
    .fn_x      (fn_x),
    .fn_y      (fn_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .clr_counts(clr_counts),
    .eval_count(eval_count),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the vtx1 PLA: x9 alone hits, x0 kills the output.
  function automatic logic vtx1(input logic [VW-1:0] x);
    return !x[0] && (x[9] || (x[3] && x[5]));
  endfunction

  assign fn_y = vtx1(fn_x);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: at most one evaluation in flight, one held result.
  logic          m_busy, m_hold, m_y, m_ok;
  int            m_gid, m_id, m_last, m_eval, m_hit, m_g;
  logic [VW-1:0] m_vec, m_fnx;
  logic [NR-1:0] m_ready;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_hold = 1'b0; m_y = 1'b0; m_id = 0; m_gid = 0;
      m_last = NR - 1; m_eval = 0; m_hit = 0; m_vec = '0; m_fnx = '0;
    end else begin
      m_ok = !m_busy && (!m_hold || rsp_ready);
      m_g  = -1;
      for (int k = 1; k <= NR; k++)
        if (m_g < 0 && req_valid[(m_last + k) % NR]) m_g = (m_last + k) % NR;
      m_ready = '0;
      if (m_ok && m_g >= 0) m_ready[m_g] = 1'b1;

      chk("m_req_ready", req_ready, m_ready);
      chk("m_rsp_valid", rsp_valid, m_hold);
      chk("m_fn_x", fn_x, m_fnx);
      chk("m_eval_count", eval_count, m_eval);
      chk("m_hit_count", hit_count, m_hit);
      if (m_hold) begin
        chk("m_rsp_id", rsp_id, m_id);
        chk("m_rsp_y", rsp_y, m_y);
      end

      if (m_busy) begin
        m_y    = vtx1(m_vec);
        m_id   = m_gid;
        m_hold = 1'b1;
        m_busy = 1'b0;
        m_eval = (m_eval < MAX) ? m_eval + 1 : MAX;
        if (m_y) m_hit = (m_hit < MAX) ? m_hit + 1 : MAX;
      end else if (m_hold && rsp_ready) begin
        m_hold = 1'b0;
      end
      if (clr_counts) begin
        m_eval = 0;
        m_hit  = 0;
      end
      if (m_ok && m_g >= 0) begin
        m_busy = 1'b1;
        m_vec  = req_vec[m_g*VW +: VW];
        m_gid  = m_g;
        m_last = m_g;
        m_fnx  = m_vec;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int r, input logic [VW-1:0] v, input logic exp_y);
    tick();
    req_valid[r] = 1'b1;
    req_vec[r*VW +: VW] = v;
    #1 chk("accept_strobe", req_ready, 32'(1 << r));
    tick();
    req_valid[r] = 1'b0;
    #1 chk("no_rsp_in_eval", rsp_valid, 0);
    tick();
    #1;
    chk("rsp_valid_n2", rsp_valid, 1);
    chk("rsp_id", rsp_id, r);
    chk("rsp_y", rsp_y, exp_y);
  endtask

  int grants[$];
  int ids[$];

  initial begin
    req_valid  = '0;
    req_vec    = '0;
    rsp_ready  = 1'b1;
    clr_counts = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_fn_x", fn_x, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_y", rsp_y, 0);
    chk("reset_eval", eval_count, 0);
    chk("reset_hit", hit_count, 0);
    chk("reset_req_ready", req_ready, 0);
    rst = 1'b0;

    // Single hit and two misses.
    run_one(0, 27'h0000200, 1'b1);
    run_one(0, 27'h0000000, 1'b0);
    run_one(1, 27'h0000201, 1'b0);
    tick();
    #1;
    chk("counts_eval_3", eval_count, 3);
    chk("counts_hit_1", hit_count, 1);

    // Round-robin with both requesters always valid.
    req_valid = 2'b11;
    req_vec   = {27'h0000200, 27'h0000028};
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rsp_valid) ids.push_back(int'(rsp_id));
      if (req_ready != '0) grants.push_back(req_ready == 2'b10 ? 1 : 0);
      tick();
      if (grants.size() >= 4) req_valid = '0;
    end
    chk("rr_grant_count", grants.size(), 4);
    chk("rr_rsp_count", ids.size(), 4);
    foreach (grants[i]) chk("rr_grant_seq", grants[i], i % 2);
    foreach (ids[i]) chk("rr_rsp_id_seq", ids[i], i % 2);

    // Backpressure with requester 1 pending.
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_vec   = {27'h0000000, 27'h0000200};
    #1 chk("bp_accept0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1 chk("bp_eval_no_ready", req_ready, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_y", rsp_y, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_hold_no_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_same_cycle_grant", req_ready, 2'b10);
    tick();
    req_valid = '0;
    #1 chk("bp_valid_drop", rsp_valid, 0);
    tick();
    #1;
    chk("bp_req1_valid", rsp_valid, 1);
    chk("bp_req1_id", rsp_id, 1);
    chk("bp_req1_y", rsp_y, 0);

    // Saturation: clear, then 17 hits on a 4-bit counter.
    tick();
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    #1;
    chk("clr_eval", eval_count, 0);
    chk("clr_hit", hit_count, 0);
    for (int i = 0; i < 17; i++) run_one(0, 27'h0000200, 1'b1);
    tick();
    #1;
    chk("sat_hit_15", hit_count, 15);
    chk("sat_eval_15", eval_count, 15);

    // Clear coinciding with the end of an evaluation.
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    clr_counts   = 1'b1;
    tick();
    clr_counts = 1'b0;
    #1;
    chk("clr_wins_eval", eval_count, 0);
    chk("clr_wins_hit", hit_count, 0);
    chk("clr_wins_rsp", rsp_valid, 1);

    // Asynchronous reset in the middle of an evaluation.
    tick();
    req_valid = 2'b01;
    req_vec   = {27'h0000200, 27'h0000200};
    tick();
    req_valid = '0;
    chk("pre_rst_fn_x", fn_x, 27'h0000200);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_fn_x", fn_x, 0);
    #1 rst = 1'b0;
    tick();
    req_valid = 2'b11;
    #1 chk("post_rst_req0_first", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 1);
    chk("post_rst_rsp_id", rsp_id, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
